// File: rtl/clk_gate_pkg.sv
// Shared definitions for the gated-domain scheduler and its helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clk_gate_pkg;

    // Scheduler states; encoding is fixed so debug taps read consistently.
    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_WAKE   = 3'd1,
        ST_ARB    = 3'd2,
        ST_RUN    = 3'd3,
        ST_LINGER = 3'd4,
        ST_SHUT   = 3'd5
    } state_t;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_WAKE_CYC     = 2;
    localparam int DEF_IDLE_TIMEOUT = 16;

    // Width needed to count up to the larger of the two phase lengths.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping to bit 0.
// Latency: purely combinational.
// Backpressure: none; valid is low when no request is set.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     pick,
    output logic             valid
);

    // Scan offsets 0..N-1 from ptr; the first requesting position wins.
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!valid && req[k] && (k == ((int'(ptr) + i) % N))) begin
                    pick[k] = 1'b1;
                    valid   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/clock_gate_ctrl.sv
// Gated-domain scheduler: wakes the domain, grants requesters round-robin, lingers, shuts down.
// Latency: request to grant WAKE_CYC+2 cycles from OFF; done to next grant 2 cycles.
// Backpressure: a grant is held until the grantee's done pulse; never preempted.
module clock_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int WAKE_CYC     = DEF_WAKE_CYC,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter int CNT_W        = cnt_width(WAKE_CYC, IDLE_TIMEOUT)
) (
    input  logic               clk_i,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] done_i,
    input  logic               force_off_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               clk_en_o,
    output logic               clk_end_o,
    output logic               domain_on_o,
    output logic               busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_REQ-1:0] pick;
    logic               pick_vld;
    logic [PTR_W-1:0]   gnt_idx;
    logic               done_hit;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic               clk_en_nxt;
    logic               clk_end_nxt;
    logic               on_nxt;

    rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req_i),
        .ptr   (rr_ptr),
        .pick  (pick),
        .valid (pick_vld)
    );

    // Only the current grantee's done bit can end its tenure.
    assign done_hit = |(done_i & gnt_o);

    // Encode the held one-hot grant so the pointer can advance past it.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_o[i]) gnt_idx = PTR_W'(i);
        end
    end

    // State, pointer, counter and registered outputs; reset drops everything without an end pulse.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state       <= ST_OFF;
            rr_ptr      <= '0;
            cnt         <= '0;
            gnt_o       <= '0;
            clk_en_o    <= 1'b0;
            clk_end_o   <= 1'b0;
            domain_on_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            cnt         <= cnt_nxt;
            gnt_o       <= gnt_nxt;
            clk_en_o    <= clk_en_nxt;
            clk_end_o   <= clk_end_nxt;
            domain_on_o <= on_nxt;
            busy_o      <= on_nxt;
        end
    end

    // Next-state, phase counter and round-robin pointer update.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rr_ptr_nxt = rr_ptr;
        case (state)
            ST_OFF: begin
                if (|req_i && !force_off_i) begin
                    state_nxt = ST_WAKE;
                    cnt_nxt   = '0;
                end
            end
            ST_WAKE: begin
                // Requests and force-off are deliberately ignored while the clock settles.
                if (cnt == CNT_W'(WAKE_CYC - 1)) begin
                    state_nxt = ST_ARB;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_ARB: begin
                if (force_off_i) begin
                    state_nxt = ST_SHUT;
                end else if (pick_vld) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_LINGER;
                    cnt_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (done_hit) begin
                    state_nxt  = ST_ARB;
                    rr_ptr_nxt = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
                end
            end
            ST_LINGER: begin
                if (force_off_i) begin
                    state_nxt = ST_SHUT;
                end else if (|req_i) begin
                    state_nxt = ST_ARB;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(IDLE_TIMEOUT - 1)) begin
                    state_nxt = ST_SHUT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_SHUT: begin
                state_nxt = ST_OFF;
            end
            default: begin
                state_nxt = ST_OFF;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the transition being taken.
    always_comb begin
        gnt_nxt     = '0;
        if (state_nxt == ST_RUN) begin
            gnt_nxt = (state == ST_ARB) ? pick : gnt_o;
        end
        clk_en_nxt  = (state == ST_OFF) && (state_nxt == ST_WAKE);
        clk_end_nxt = (state_nxt == ST_SHUT);
        on_nxt      = (state_nxt != ST_OFF);
    end

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl with a cycle model compared every cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_clock_gate_ctrl;

    localparam int N  = 4;
    localparam int WK = 2;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_i;
    logic [N-1:0] done_i;
    logic         force_off_i;
    logic [N-1:0] gnt_o;
    logic         clk_en_o;
    logic         clk_end_o;
    logic         domain_on_o;
    logic         busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int n_en     = 0;
    int n_end    = 0;

    clock_gate_ctrl #(
        .NUM_REQ      (N),
        .WAKE_CYC     (WK),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk_i       (clk),
        .rst         (rst),
        .req_i       (req_i),
        .done_i      (done_i),
        .force_off_i (force_off_i),
        .gnt_o       (gnt_o),
        .clk_en_o    (clk_en_o),
        .clk_end_o   (clk_end_o),
        .domain_on_o (domain_on_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- behavioural model ----------------
    // Domain described by "on" flag plus which phase is pending: remaining wake cycles,
    // a pending arbitration, a current grantee, elapsed idle cycles, or a shutdown cycle.
    bit m_active = 1'b0;
    bit m_en     = 1'b0;
    bit m_shut   = 1'b0;
    bit m_arb    = 1'b0;
    int m_wake_left = 0;
    int m_grant  = -1;
    int m_idle   = -1;
    int m_next   = 0;

    function automatic int first_from(input logic [N-1:0] r, input int start);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (start + i) % N;
            if (((r >> k) & 1) != 0) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        if (idx >= 0) v = N'(1) << idx;
        return v;
    endfunction

    task automatic model_step();
        m_en = 1'b0;
        if (rst) begin
            m_active = 0; m_shut = 0; m_arb = 0; m_wake_left = 0;
            m_grant = -1; m_idle = -1; m_next = 0;
        end else if (!m_active) begin
            if (req_i != 0 && !force_off_i) begin
                m_active = 1; m_en = 1; m_wake_left = WK;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
            if (m_wake_left == 0) m_arb = 1;
        end else if (m_arb) begin
            m_arb = 0;
            if (force_off_i) m_shut = 1;
            else if (req_i != 0) m_grant = first_from(req_i, m_next);
            else m_idle = 0;
        end else if (m_grant >= 0) begin
            if ((done_i & onehot(m_grant)) != 0) begin
                m_next = (m_grant + 1) % N;
                m_grant = -1;
                m_arb = 1;
            end
        end else if (m_idle >= 0) begin
            if (force_off_i) begin
                m_idle = -1; m_shut = 1;
            end else if (req_i != 0) begin
                m_idle = -1; m_arb = 1;
            end else if (m_idle == TO - 1) begin
                m_idle = -1; m_shut = 1;
            end else begin
                m_idle++;
            end
        end else if (m_shut) begin
            m_shut = 0; m_active = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, plus pulse counting.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("model_gnt",       32'(gnt_o),       32'(onehot(m_grant)));
            check("model_clk_en",    32'(clk_en_o),    32'(m_en));
            check("model_clk_end",   32'(clk_end_o),   32'(m_shut));
            check("model_domain_on", 32'(domain_on_o), 32'(m_active));
            check("model_busy",      32'(busy_o),      32'(m_active));
            if (clk_en_o === 1'b1)  n_en++;
            if (clk_end_o === 1'b1) n_end++;
        end
    end

    task automatic wait_gnt(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (gnt_o != 0) begin
                seen = 1'b1;
                break;
            end
            step(1);
        end
        check("wait_gnt_bound", 32'(seen), 32'd1);
    endtask

    task automatic wait_off(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (busy_o === 1'b0) begin
                seen = 1'b1;
                break;
            end
            step(1);
        end
        check("wait_off_bound", 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    logic [N-1:0] rr_exp [5];
    int en0, end0;

    initial begin
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        rst = 1'b1; req_i = '0; done_i = '0; force_off_i = 1'b0;
        step(3);
        chk_en = 1'b1;
        check("reset_gnt",     32'(gnt_o),       32'd0);
        check("reset_clk_en",  32'(clk_en_o),    32'd0);
        check("reset_clk_end", 32'(clk_end_o),   32'd0);
        check("reset_busy",    32'(busy_o),      32'd0);
        rst = 1'b0;

        // Cold wake
        req_i = 4'b0100;
        step(1);
        check("cold_clk_en_c1", 32'(clk_en_o), 32'd1);
        check("cold_busy_c1",   32'(busy_o),   32'd1);
        step(3);
        check("cold_gnt_c4", 32'(gnt_o), 32'b0100);
        req_i = '0;
        step(6);
        done_i = 4'b0100;
        step(1);
        done_i = '0;
        check("cold_gnt_c11", 32'(gnt_o), 32'd0);
        step(17);
        check("cold_clk_end_c28", 32'(clk_end_o), 32'd1);
        step(1);
        check("cold_busy_c29", 32'(busy_o),      32'd0);
        check("cold_on_c29",   32'(domain_on_o), 32'd0);

        // Round-robin with a fresh pointer
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        en0 = n_en; end0 = n_end;
        req_i = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [N-1:0] g;
            wait_gnt(20);
            g = gnt_o;
            check($sformatf("rr_grant_%0d", k), 32'(g), 32'(rr_exp[k]));
            if (k == 4) req_i = '0;
            step(3);
            done_i = g;
            step(1);
            done_i = '0;
            check($sformatf("rr_gap_%0d", k), 32'(gnt_o), 32'd0);
        end
        check("rr_single_clk_en", 32'(n_en - en0), 32'd1);

        // Linger re-use: request at linger cycle 10
        step(11);
        req_i = 4'b1000;
        step(2);
        check("linger_gnt", 32'(gnt_o), 32'b1000);
        req_i = '0;
        check("linger_no_end", 32'(n_end - end0), 32'd0);
        check("linger_no_en",  32'(n_en - en0),   32'd1);
        step(1);
        done_i = 4'b1000;
        step(1);
        done_i = '0;
        step(17);
        check("linger_full_end", 32'(clk_end_o), 32'd1);
        step(1);
        check("linger_off", 32'(busy_o), 32'd0);
        check("linger_end_count", 32'(n_end - end0), 32'd1);

        // Force-off during RUN
        req_i = 4'b0010;
        step(4);
        check("force_gnt", 32'(gnt_o), 32'b0010);
        force_off_i = 1'b1;
        req_i = 4'b0011;
        step(3);
        check("force_no_preempt", 32'(gnt_o), 32'b0010);
        done_i = 4'b0010;
        step(1);
        done_i = '0;
        check("force_arb_gnt0", 32'(gnt_o), 32'd0);
        step(1);
        check("force_clk_end", 32'(clk_end_o), 32'd1);
        step(1);
        check("force_off_state", 32'(busy_o), 32'd0);
        step(2);
        check("force_holds_off", 32'(busy_o), 32'd0);
        force_off_i = 1'b0;
        req_i = '0;
        step(1);

        // Non-granted done is ignored
        req_i = 4'b0010;
        step(4);
        check("stray_gnt", 32'(gnt_o), 32'b0010);
        step(1);
        done_i = 4'b0001;
        step(1);
        done_i = '0;
        check("stray_done_ignored", 32'(gnt_o), 32'b0010);
        step(1);
        done_i = 4'b0010;
        step(1);
        done_i = '0;
        req_i = '0;
        check("stray_release", 32'(gnt_o), 32'd0);
        wait_off(40);
        step(1);

        // Request withdrawn during WAKE
        req_i = 4'b0001;
        step(1);
        req_i = '0;
        step(19);
        check("withdraw_clk_end_c20", 32'(clk_end_o), 32'd1);
        step(1);
        check("withdraw_off_c21", 32'(busy_o), 32'd0);

        // Synchronous reset mid-RUN
        req_i = 4'b1111;
        wait_gnt(20);
        rst = 1'b1;
        step(1);
        check("rst_gnt",       32'(gnt_o),       32'd0);
        check("rst_clk_en",    32'(clk_en_o),    32'd0);
        check("rst_clk_end",   32'(clk_end_o),   32'd0);
        check("rst_domain_on", 32'(domain_on_o), 32'd0);
        check("rst_busy",      32'(busy_o),      32'd0);
        rst = 1'b0;
        step(4);
        check("rst_first_gnt", 32'(gnt_o), 32'b0001);
        req_i = '0;
        done_i = 4'b0001;
        step(1);
        done_i = '0;
        wait_off(40);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
